adder_share_arbiter: RTL and testbench

Clocked arbiter that shares one adder datapath between `NREQ` requesters. Each requester offers an operand pair over a valid/ready handshake, the clocked counterpart of a blocking channel Send. The block selects one requester per cycle by round-robin, registers the sum with its carry and the winner's index, and holds the result on a single-entry output port until the consumer accepts it. It sits between the operand-generating pipelines and the downstream result sink.

---
 rtl/adder_share_arbiter_if.sv | 26 ++
 rtl/adder_share_arbiter.sv | 105 ++++++++++
 tb/tb_adder_share_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_arbiter_if.sv
// rtl/adder_share_arbiter_if.sv - requester/consumer signal bundle for adder_share_arbiter
interface adder_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_sum;
  logic                  res_carry;
  logic [IDW-1:0]        res_id;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_carry, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_carry, res_id
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin shared adder with a single-entry result register
// ADD_SHARE_FIXED_PRIO_EN selects lowest-index-wins priority instead of round-robin.
module adder_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input logic                  clk,
  input logic                  rst,
  adder_share_arbiter_if.slave bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   start_idx;
  logic [IDW-1:0]   win_idx;
  logic             found;
  logic             can_issue;
  logic             grant;
  logic [WIDTH:0]   win_total;

  // Index offset positions from base, wrapping modulo NREQ.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offset);
    int s;
    s = int'(base) + offset;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

`ifdef ADD_SHARE_FIXED_PRIO_EN
  assign start_idx = '0;
`else
  logic [IDW-1:0] ptr_q, ptr_d;

  assign start_idx = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = rr_index(win_idx, 1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req_valid[rr_index(start_idx, k)]) begin
        found   = 1'b1;
        win_idx = rr_index(start_idx, k);
      end
    end
  end

  // A held result blocks new grants unless it is being accepted this cycle.
  assign can_issue = (state_q == EMPTY) || bus.res_ready;
  assign grant     = found && can_issue && !rst;
  assign win_total = {1'b0, bus.req_a[int'(win_idx)*WIDTH +: WIDTH]}
                   + {1'b0, bus.req_b[int'(win_idx)*WIDTH +: WIDTH]};

  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    id_d    = id_q;
    if (grant) begin
      state_d          = FULL;
      {carry_d, sum_d} = win_total;
      id_d             = win_idx;
    end else if (state_q == FULL && bus.res_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      id_q    <= id_d;
    end
  end

  assign bus.res_valid = (state_q == FULL);
  assign bus.res_sum   = sum_q;
  assign bus.res_carry = carry_q;
  assign bus.res_id    = id_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - directed and random checks of adder_share_arbiter against a behavioural model
module tb_adder_share_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  adder_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic       req_v [NREQ];
  logic [7:0] op_a  [NREQ];
  logic [7:0] op_b  [NREQ];

  int         m_ptr   = 0;
  bit         m_full  = 1'b0;
  logic [7:0] m_sum   = '0;
  logic       m_carry = 1'b0;
  logic [1:0] m_id    = '0;
  int         last_grant;

  logic [3:0] obs_ready;
  logic       obs_valid;
  logic [7:0] obs_sum;
  logic       obs_carry;
  logic [1:0] obs_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input bit r, input bit rr);
    int start;
    if (r) return -1;
    if (m_full && !rr) return -1;
`ifdef ADD_SHARE_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (req_v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic cycle(input bit r, input bit rr);
    int         g;
    logic [8:0] total;
    rst           = r;
    bus.res_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]          = req_v[i];
      bus.req_a[i*WIDTH +: WIDTH] = op_a[i];
      bus.req_b[i*WIDTH +: WIDTH] = op_b[i];
    end
    @(negedge clk);
    obs_ready = bus.req_ready;
    obs_valid = bus.res_valid;
    obs_sum   = bus.res_sum;
    obs_carry = bus.res_carry;
    obs_id    = bus.res_id;
    g = model_winner(r, rr);
    check("req_ready", 32'(obs_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    check("res_valid", 32'(obs_valid), 32'(m_full));
    check("res_sum",   32'(obs_sum),   32'(m_sum));
    check("res_carry", 32'(obs_carry), 32'(m_carry));
    check("res_id",    32'(obs_id),    32'(m_id));
    if (r) begin
      m_ptr = 0; m_full = 1'b0; m_sum = '0; m_carry = 1'b0; m_id = '0;
    end else if (g >= 0) begin
      total   = 9'(op_a[g]) + 9'(op_b[g]);
      m_sum   = total[7:0];
      m_carry = total[8];
      m_id    = 2'(g);
      m_full  = 1'b1;
      m_ptr   = (g + 1) % NREQ;
    end else if (rr) begin
      m_full = 1'b0;
    end
    last_grant = g;
    @(posedge clk);
    #1;
  endtask

  task automatic update_reqs(input bit keep_all);
    if (last_grant >= 0) req_v[last_grant] = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!req_v[i] && (keep_all || $urandom_range(0, 1) == 1)) begin
        req_v[i] = 1'b1;
        op_a[i]  = 8'($urandom);
        op_b[i]  = 8'($urandom);
      end
    end
  endtask

  task automatic set_all(input bit v);
    for (int i = 0; i < NREQ; i++) begin
      req_v[i] = v;
      op_a[i]  = 8'($urandom);
      op_b[i]  = 8'($urandom);
    end
  endtask

  logic [3:0] rr_order [6];

  initial begin
`ifdef ADD_SHARE_FIXED_PRIO_EN
    rr_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
`endif
    set_all(1'b1);
    rst           = 1'b1;
    bus.res_ready = 1'b1;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1);
      check("reset_ready", 32'(obs_ready), 32'd0);
      check("reset_valid", 32'(obs_valid), 32'd0);
    end

    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1);
      check($sformatf("rr_grant_%0d", i), 32'(obs_ready), 32'(rr_order[i]));
      update_reqs(1'b1);
    end

    set_all(1'b0);
    cycle(1'b0, 1'b1);
    req_v[2] = 1'b1; op_a[2] = 8'h7F; op_b[2] = 8'h01;
    cycle(1'b0, 1'b1);
    check("single_ready", 32'(obs_ready), 32'h4);
    req_v[2] = 1'b0;
    req_v[1] = 1'b1; op_a[1] = 8'hFF; op_b[1] = 8'h02;
    cycle(1'b0, 1'b1);
    check("single_sum",   32'(obs_sum),   32'h80);
    check("single_carry", 32'(obs_carry), 32'h0);
    check("single_id",    32'(obs_id),    32'h2);
    req_v[1] = 1'b0;
    cycle(1'b0, 1'b1);
    check("ovf_sum",   32'(obs_sum),   32'h01);
    check("ovf_carry", 32'(obs_carry), 32'h1);
    check("ovf_id",    32'(obs_id),    32'h1);

    set_all(1'b1);
    cycle(1'b0, 1'b1);
    update_reqs(1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0);
      check("bp_ready", 32'(obs_ready), 32'd0);
      check("bp_valid", 32'(obs_valid), 32'd1);
    end
    cycle(1'b0, 1'b1);
    check("bp_release_grant", 32'(obs_ready != 4'b0000), 32'd1);
    update_reqs(1'b1);
    cycle(1'b0, 1'b1);

    set_all(1'b0);
    cycle(1'b0, 1'b1);
    req_v[3] = 1'b1; op_a[3] = 8'h12; op_b[3] = 8'h34;
    cycle(1'b0, 1'b1);
    req_v[3] = 1'b0;
    cycle(1'b0, 1'b0);
    check("mid_hold_valid", 32'(obs_valid), 32'd1);
    check("mid_hold_id",    32'(obs_id),    32'd3);
    check("mid_hold_sum",   32'(obs_sum),   32'h46);
    set_all(1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    check("mid_reset_valid", 32'(obs_valid), 32'd0);
    check("mid_reset_grant", 32'(obs_ready), 32'h1);
    update_reqs(1'b1);

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0);
      update_reqs(1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
